flags_gen: RTL
==============

# flags_gen

Producer side of the condition-flag path. It computes ZF/SF/CF/OF from ALU operand/result information and holds them in the architectural FLAGS register. It drives the registered flags, plus a same-cycle next-value, to the jump/branch condition evaluator. An optional small save/restore stack supports pushf/popf-style instructions.

## Interface
- WIDTH, 32, ALU datapath width in bits
- STACK_DEPTH, 4, number of flag-save entries (≥1; used only with stack compiled in)

- CLK  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- valid_i  in  1  flag-update request this cycle
- op_cls  in  2  00 none, 01 add, 10 sub, 11 logic
- a_i, b_i  in  WIDTH  ALU operands
- res_i  in  WIDTH  ALU result (must equal a+b / a−b for add/sub)
- wr_mask  in  4  per-flag write enable {ZF,SF,CF,OF}
- stall  in  1  freeze: blocks update, push and pop
- push  in  1  save current flags_o to stack
- pop  in  1  restore top of stack into FLAGS
- flags_o  out  FLAGS_t  registered architectural flags
- flags_next  out  FLAGS_t  combinational value flags_o takes at next edge
- stack_full  out  1  stack holds STACK_DEPTH entries
- stack_empty  out  1  stack holds 0 entries
- stack_err  out  1  sticky overflow/underflow/conflict error

## Operation
- Generated flags (cand), all from res_i/a_i/b_i with m = WIDTH−1:
  - ZF = (res_i == 0); SF = res_i[m] for every op_cls ≠ 00.
  - add: CF = carry out of the internal (WIDTH+1)-bit a_i+b_i; OF = (a_i[m]==b_i[m]) && (res_i[m]!=a_i[m]).
  - sub: CF = (a_i < b_i), unsigned borrow; OF = (a_i[m]!=b_i[m]) && (res_i[m]!=a_i[m]).
  - logic: CF = 0, OF = 0.
  - op_cls 00: no update regardless of valid_i.
- Update: when valid_i && !stall && op_cls≠00 && no pop fires, each flag with its wr_mask bit set takes cand; unmasked flags hold.
- Priority per cycle (stall=0): pop > update. A push saves the pre-update flags_o; an update in the same cycle still applies.
- push && pop together: both ignored, stack_err←1; the update still applies.
- push when full, or pop when empty: ignored, stack_err←1; the update still applies.
- Stack is a LIFO with pointer sp ∈ 0..STACK_DEPTH; stack_empty = (sp==0), stack_full = (sp==STACK_DEPTH).
- stack_err is cleared only by reset.
- flags_next always equals the value registered at the next edge, including during stall (holds flags_o) and pop (stack top).

## Timing
- Reset (async): flags_o = 0, sp = 0, stack_empty = 1, stack_full = 0, stack_err = 0; stack contents don't-care.
- Update latency 1 cycle: request in cycle n → flags_o valid in n+1; flags_next valid in cycle n (combinational, no loop through flags_o consumers).
- Pop: restored flags appear on flags_o at n+1; sp decrements at the same edge.
- Push: entry written and sp increments at the edge ending cycle n.
- stall=1: all state holds; requests are dropped, not queued. Stalled cycles raise no error.
- Reset mid-sequence discards the stack and the pending update immediately.

## Configuration
- FLAGS_STACK_EN defined: save/restore stack, push/pop and error logic compiled in as above.
- Not defined: no stack storage; push/pop ignored; stack_empty = 1, stack_full = 0, stack_err = 0 constant; update path unchanged.

## Test plan
- WIDTH=8, add, a=7F, b=01, res=80, mask=F → flags_o next cycle ZF=0, SF=1, CF=0, OF=1.
- sub a=03, b=05, res=FE, mask=F → CF=1, SF=1, ZF=0, OF=0. Then sub a=05, b=05, res=00 → ZF=1, CF=0.
- Flags at ZF=1,CF=1; logic res=00 with mask={ZF}=1000 → ZF=1, CF stays 1; mask=0110 with res=80 → SF=1, CF=0, ZF unchanged.
- Stack (STACK_DEPTH=4):
  - 4 pushes of distinct flags → stack_full=1.
  - 5th push → stack_err=1, sp stays 4.
  - 4 pops → values restored in LIFO order; stack_empty=1.
  - Extra pop → flags unchanged, stack_err remains 1.
- Same cycle: pop with valid_i add → flags_o = popped value. Same cycle: push with update → stack holds old flags, flags_o = new flags.
- stall=1 with valid_i/push/pop asserted for 3 cycles → flags_o, sp, stack_err unchanged. Assert rst_n low mid-stall → all outputs return to reset values without a clock edge.

Source files
------------

// File: rtl/flags_gen_if.sv
// Condition-flag request/response bundle shared by the ALU side and the flags_gen producer.
// The package holds the FLAGS_t layout {ZF,SF,CF,OF}; the bit order matches wr_mask.
package flags_gen_pkg;
  typedef struct packed {
    logic zf;
    logic sf;
    logic cf;
    logic of;
  } FLAGS_t;

  localparam logic [1:0] OP_NONE  = 2'b00;
  localparam logic [1:0] OP_ADD   = 2'b01;
  localparam logic [1:0] OP_SUB   = 2'b10;
  localparam logic [1:0] OP_LOGIC = 2'b11;
endpackage

interface flags_gen_if #(parameter int WIDTH = 32);
  import flags_gen_pkg::*;

  logic             valid_i;
  logic [1:0]       op_cls;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic [WIDTH-1:0] res_i;
  logic [3:0]       wr_mask;
  logic             stall;
  logic             push;
  logic             pop;
  FLAGS_t           flags_o;
  FLAGS_t           flags_next;
  logic             stack_full;
  logic             stack_empty;
  logic             stack_err;

  modport master (
    output valid_i, op_cls, a_i, b_i, res_i, wr_mask, stall, push, pop,
    input  flags_o, flags_next, stack_full, stack_empty, stack_err
  );

  modport slave (
    input  valid_i, op_cls, a_i, b_i, res_i, wr_mask, stall, push, pop,
    output flags_o, flags_next, stack_full, stack_empty, stack_err
  );
endinterface

// File: rtl/flags_gen.sv
// Architectural FLAGS register: generates ZF/SF/CF/OF from ALU results, with an
// optional pushf/popf LIFO compiled in when FLAGS_STACK_EN is defined.
module flags_gen
  import flags_gen_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int STACK_DEPTH = 4
) (
  input logic        CLK,
  input logic        rst_n,
  flags_gen_if.slave bus
);

  localparam int M = WIDTH - 1;

  FLAGS_t           flags_q, flags_d;
  FLAGS_t           cand;
  FLAGS_t           pop_val;
  logic             pop_fire;
  logic             upd_fire;
  logic             add_co;
  logic [WIDTH-1:0] unused_add_sum;

  always_comb begin
    {add_co, unused_add_sum} = {1'b0, bus.a_i} + {1'b0, bus.b_i};
    cand    = '0;
    cand.zf = (bus.res_i == '0);
    cand.sf = bus.res_i[M];
    case (bus.op_cls)
      OP_ADD: begin
        cand.cf = add_co;
        cand.of = (bus.a_i[M] == bus.b_i[M]) && (bus.res_i[M] != bus.a_i[M]);
      end
      OP_SUB: begin
        cand.cf = (bus.a_i < bus.b_i);
        cand.of = (bus.a_i[M] != bus.b_i[M]) && (bus.res_i[M] != bus.a_i[M]);
      end
      default: ;
    endcase
  end

`ifdef FLAGS_STACK_EN
  localparam int SPW = $clog2(STACK_DEPTH + 1);
  localparam int IW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [SPW-1:0] sp_q, sp_d;
  logic           err_q, err_d;
  FLAGS_t         stk_q [STACK_DEPTH];
  logic           push_req, pop_req, push_fire;
  logic           full, empty;
  logic [IW-1:0]  wr_idx, rd_idx;

  always_comb begin
    full      = (sp_q == SPW'(STACK_DEPTH));
    empty     = (sp_q == '0);
    push_req  = bus.push && !bus.stall;
    pop_req   = bus.pop  && !bus.stall;
    // Simultaneous push+pop is an error and neither side acts.
    push_fire = push_req && !pop_req && !full;
    pop_fire  = pop_req && !push_req && !empty;
    err_d     = err_q | (push_req && pop_req)
                      | (push_req && !pop_req && full)
                      | (pop_req && !push_req && empty);
    wr_idx    = IW'(sp_q);
    rd_idx    = IW'(sp_q - 1'b1);
    pop_val   = stk_q[rd_idx];
    sp_d      = sp_q;
    if (push_fire)     sp_d = sp_q + 1'b1;
    else if (pop_fire) sp_d = sp_q - 1'b1;
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      sp_q  <= '0;
      err_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      err_q <= err_d;
    end
  end

  // Entry contents need no reset; sp alone defines validity.
  always_ff @(posedge CLK) begin
    if (push_fire) stk_q[wr_idx] <= flags_q;
  end

  assign bus.stack_full  = full;
  assign bus.stack_empty = empty;
  assign bus.stack_err   = err_q;
`else
  logic unused_stk;

  assign unused_stk      = ^{bus.push, bus.pop};
  assign pop_fire        = 1'b0;
  assign pop_val         = '0;
  assign bus.stack_full  = 1'b0;
  assign bus.stack_empty = 1'b1;
  assign bus.stack_err   = 1'b0;
`endif

  always_comb begin
    upd_fire = bus.valid_i && !bus.stall && (bus.op_cls != OP_NONE) && !pop_fire;
    flags_d  = flags_q;
    if (pop_fire)
      flags_d = pop_val;
    else if (upd_fire)
      flags_d = FLAGS_t'((flags_q & ~bus.wr_mask) | (cand & bus.wr_mask));
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) flags_q <= '0;
    else        flags_q <= flags_d;
  end

  assign bus.flags_o    = flags_q;
  assign bus.flags_next = flags_d;

endmodule
